hilo_acc_bank: RTL

- Parametrised multi-channel HI/LO accumulator bank for the execute stage; successor to the single HI/LO pair.
- Holds NCH accumulator pairs (ac0..acN-1, as for DSP-style multiple accumulators), each pair WIDTH-bit HI plus WIDTH-bit LO.
- Supports direct MTHI/MTLO writes with same-cycle read bypass, plus a 2-stage pipelined accumulate path (MADD/MSUB/load) that takes a precomputed 2*WIDTH product.
- Pipeline flush kills in-flight accumulates.

---
 rtl/hilo_acc_bank_if.sv | 39 +++
 rtl/hilo_acc_bank.sv | 128 ++++++++++++
 2 files changed

// File: rtl/hilo_acc_bank_if.sv
// Bus bundle for the HI/LO accumulator bank: direct read/write port plus the
// accumulate request/completion signals. clk and rst stay outside the bundle.
interface hilo_acc_bank_if #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int SELW  = 2
);
  logic               we_hi;
  logic               we_lo;
  logic [SELW-1:0]    wsel;
  logic [WIDTH-1:0]   wd_hi;
  logic [WIDTH-1:0]   wd_lo;
  logic [SELW-1:0]    rsel;
  logic [WIDTH-1:0]   rd_hi;
  logic [WIDTH-1:0]   rd_lo;
  // Handshake: a request transfers on a rising edge where acc_valid && acc_ready;
  // acc_ready has no dependency on acc_valid, and a request not accepted is simply dropped.
  logic               acc_valid;
  logic               acc_ready;
  logic [SELW-1:0]    acc_sel;
  logic [1:0]         acc_op;
  logic [2*WIDTH-1:0] acc_prod;
  logic               flush;
  logic               acc_done;
  logic [SELW-1:0]    acc_wsel;
  logic [NCH-1:0]     pend_mask;

  modport master (
    output we_hi, we_lo, wsel, wd_hi, wd_lo, rsel,
    output acc_valid, acc_sel, acc_op, acc_prod, flush,
    input  rd_hi, rd_lo, acc_ready, acc_done, acc_wsel, pend_mask
  );

  modport slave (
    input  we_hi, we_lo, wsel, wd_hi, wd_lo, rsel,
    input  acc_valid, acc_sel, acc_op, acc_prod, flush,
    output rd_hi, rd_lo, acc_ready, acc_done, acc_wsel, pend_mask
  );
endinterface

// File: rtl/hilo_acc_bank.sv
// Multi-channel HI/LO accumulator bank: direct writes with same-cycle read
// bypass, plus a two-stage (A: capture, B: compute/write) accumulate pipeline.
module hilo_acc_bank #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input logic            clk,
  input logic            rst,
  hilo_acc_bank_if.slave bus
);
  localparam int PW = 2 * WIDTH;

  logic [WIDTH-1:0] r_hi [NCH];
  logic [WIDTH-1:0] r_lo [NCH];

  logic             r_a_valid;
  logic [SELW-1:0]  r_a_sel;
  logic [1:0]       r_a_op;
  logic [PW-1:0]    r_a_prod;
  logic             r_b_valid;
  logic [SELW-1:0]  r_b_sel;
  logic [1:0]       r_b_op;
  logic [PW-1:0]    r_b_prod;

  logic             w_accept;
  logic             w_rsel_ok;
  logic             w_wsel_ok;
  logic             w_bsel_ok;
  logic             w_b_live;
  logic             w_b_write;
  logic [WIDTH-1:0] w_rd_hi;
  logic [WIDTH-1:0] w_rd_lo;
  logic [WIDTH-1:0] w_cur_hi;
  logic [WIDTH-1:0] w_cur_lo;
  logic [PW-1:0]    w_result;
  logic [NCH-1:0]   w_pend;

  assign w_rsel_ok = int'(bus.rsel) < NCH;
  assign w_wsel_ok = int'(bus.wsel) < NCH;
  assign w_bsel_ok = int'(r_b_sel) < NCH;
  assign w_accept  = bus.acc_valid && bus.acc_ready;
  assign w_b_live  = r_b_valid && (r_b_op != 2'b11) && !bus.flush;
  assign w_b_write = w_b_live && w_bsel_ok;

  // Out-of-range channels read as zero and never take a bypass.
  always_comb begin
    w_rd_hi = '0;
    w_rd_lo = '0;
    if (w_rsel_ok) begin
      w_rd_hi = (bus.we_hi && bus.wsel == bus.rsel) ? bus.wd_hi : r_hi[bus.rsel];
      w_rd_lo = (bus.we_lo && bus.wsel == bus.rsel) ? bus.wd_lo : r_lo[bus.rsel];
    end
  end

  // Stage B sees a same-cycle direct write, so the pair behaves as "write, then accumulate".
  always_comb begin
    w_cur_hi = '0;
    w_cur_lo = '0;
    if (w_bsel_ok) begin
      w_cur_hi = (bus.we_hi && bus.wsel == r_b_sel) ? bus.wd_hi : r_hi[r_b_sel];
      w_cur_lo = (bus.we_lo && bus.wsel == r_b_sel) ? bus.wd_lo : r_lo[r_b_sel];
    end
  end

  always_comb begin
    w_result = {w_cur_hi, w_cur_lo};
    case (r_b_op)
      2'b00:   w_result = {w_cur_hi, w_cur_lo} + r_b_prod;
      2'b01:   w_result = {w_cur_hi, w_cur_lo} - r_b_prod;
      2'b10:   w_result = r_b_prod;
      default: w_result = {w_cur_hi, w_cur_lo};
    endcase
  end

  always_comb begin
    w_pend = '0;
    for (int i = 0; i < NCH; i++) begin
      if (r_a_valid && int'(r_a_sel) == i) w_pend[i] = 1'b1;
      if (r_b_valid && int'(r_b_sel) == i) w_pend[i] = 1'b1;
    end
  end

  // Accumulate write is issued after the direct write so it wins on a clash.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++) begin
        r_hi[i] <= '0;
        r_lo[i] <= '0;
      end
    end else begin
      if (bus.we_hi && w_wsel_ok) r_hi[bus.wsel] <= bus.wd_hi;
      if (bus.we_lo && w_wsel_ok) r_lo[bus.wsel] <= bus.wd_lo;
      if (w_b_write) begin
        r_hi[r_b_sel] <= w_result[PW-1:WIDTH];
        r_lo[r_b_sel] <= w_result[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || bus.flush) begin
      r_a_valid <= 1'b0;
      r_b_valid <= 1'b0;
    end else begin
      r_a_valid <= w_accept;
      r_b_valid <= r_a_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a_sel  <= bus.acc_sel;
      r_a_op   <= bus.acc_op;
      r_a_prod <= bus.acc_prod;
    end
    r_b_sel  <= r_a_sel;
    r_b_op   <= r_a_op;
    r_b_prod <= r_a_prod;
  end

  assign bus.rd_hi     = w_rd_hi;
  assign bus.rd_lo     = w_rd_lo;
  assign bus.acc_ready = rst && !bus.flush;
  assign bus.acc_done  = w_b_live;
  assign bus.acc_wsel  = r_b_sel;
  assign bus.pend_mask = w_pend;
endmodule
